// File: rtl/fp16_pkg.sv
// FP16 field layout, special encodings, dot-unit states and the shared
// half-precision multiply used by the dot-product engine.
package fp16_pkg;

  localparam int unsigned FP16_W   = 16;
  localparam int unsigned SIGN_W   = 1;
  localparam int unsigned EXP_W    = 5;
  localparam int unsigned MAN_W    = 10;
  localparam int unsigned EXP_BIAS = 15;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_PINF = 16'h7C00;
  localparam logic [FP16_W-1:0] FP16_NINF = 16'hFC00;
  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, DONE} state_e;

  // RNE multiply; subnormals flush to signed zero, overflow saturates to inf.
  function automatic logic [FP16_W-1:0] fp16_mul(input logic [FP16_W-1:0] a,
                                                 input logic [FP16_W-1:0] b);
    logic                    s;
    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W-1:0]        ma, mb, m;
    logic                    nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [2*MAN_W+1:0]      p;
    logic                    g, st, rnd;
    logic [MAN_W:0]          mr;
    logic signed [7:0]       e;
    logic [FP16_W-1:0]       r;

    s      = a[15] ^ b[15];
    ea     = a[14:10];
    eb     = b[14:10];
    ma     = a[9:0];
    mb     = b[9:0];
    nan_a  = (ea == 5'h1F) && (ma != '0);
    nan_b  = (eb == 5'h1F) && (mb != '0);
    inf_a  = (ea == 5'h1F) && (ma == '0);
    inf_b  = (eb == 5'h1F) && (mb == '0);
    zero_a = (ea == '0);
    zero_b = (eb == '0);

    p = 22'({1'b1, ma}) * 22'({1'b1, mb});
    e = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
    if (p[21]) begin
      m  = p[20:11];
      g  = p[10];
      st = |p[9:0];
      e  = e + 8'sd1;
    end else begin
      m  = p[19:10];
      g  = p[9];
      st = |p[8:0];
    end
    rnd = g & (st | m[0]);
    mr  = {1'b0, m} + 11'(rnd);
    if (mr[10]) e = e + 8'sd1;

    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) r = FP16_QNAN;
    else if (inf_a || inf_b)   r = {s, 5'h1F, 10'h000};
    else if (zero_a || zero_b) r = {s, 15'h0000};
    else if (e >= 8'sd31)      r = {s, 5'h1F, 10'h000};
    else if (e <= 8'sd0)       r = {s, 15'h0000};
    else                       r = {s, e[4:0], mr[9:0]};
    return r;
  endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational FP16 adder: swap, align with guard/round/sticky, add/sub,
// normalise, round-to-nearest-even; subnormals flush to signed zero.
module fp16_add
  import fp16_pkg::*;
(
  input  logic [FP16_W-1:0] a_i,
  input  logic [FP16_W-1:0] b_i,
  output logic [FP16_W-1:0] sum_c_o
);

  logic             sa, sb, sl, sub, a_ge_b;
  logic [EXP_W-1:0] ea, eb, el, es, diff;
  logic [MAN_W-1:0] ma, mb;
  logic [MAN_W:0]   ml, ms, mr;
  logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [42:0]      sh;
  logic [13:0]      big, al_s;
  logic [14:0]      sum;
  logic [12:0]      nrm;
  logic [3:0]       lz;
  logic signed [6:0] e;
  logic             g, st, rnd;

  assign sa     = a_i[15];
  assign sb     = b_i[15];
  assign ea     = a_i[14:10];
  assign eb     = b_i[14:10];
  assign ma     = a_i[9:0];
  assign mb     = b_i[9:0];
  assign nan_a  = (ea == 5'h1F) && (ma != '0);
  assign nan_b  = (eb == 5'h1F) && (mb != '0);
  assign inf_a  = (ea == 5'h1F) && (ma == '0);
  assign inf_b  = (eb == 5'h1F) && (mb == '0);
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);

  // Larger magnitude becomes the reference operand.
  assign a_ge_b = (a_i[14:0] >= b_i[14:0]);
  assign sl     = a_ge_b ? sa : sb;
  assign el     = a_ge_b ? ea : eb;
  assign es     = a_ge_b ? eb : ea;
  assign ml     = {1'b1, a_ge_b ? ma : mb};
  assign ms     = {1'b1, a_ge_b ? mb : ma};
  assign sub    = sa ^ sb;
  assign diff   = el - es;
  assign sh     = {ms, 32'h0000_0000} >> diff;
  assign al_s   = {sh[42:30], |sh[29:0]};
  assign big    = {ml, 3'b000};
  assign sum    = sub ? ({1'b0, big} - {1'b0, al_s}) : ({1'b0, big} + {1'b0, al_s});

  always_comb begin
    lz      = '0;
    e       = $signed({2'b00, el});
    nrm     = '0;
    g       = 1'b0;
    st      = 1'b0;
    rnd     = 1'b0;
    mr      = '0;
    sum_c_o = FP16_ZERO;

    for (int i = 0; i < 14; i++) begin
      if (sum[i]) lz = 4'(13 - i);
    end
    if (sum[14]) begin
      nrm = {sum[13:2], sum[1] | sum[0]};
      e   = e + 7'sd1;
    end else begin
      nrm = 13'(sum[13:0] << lz);
      e   = e - $signed({3'b000, lz});
    end
    g   = nrm[2];
    st  = |nrm[1:0];
    rnd = g & (st | nrm[3]);
    mr  = {1'b0, nrm[12:3]} + 11'(rnd);
    if (mr[10]) e = e + 7'sd1;

    if (nan_a || nan_b || (inf_a && inf_b && sub)) sum_c_o = FP16_QNAN;
    else if (inf_a)             sum_c_o = {sa, 5'h1F, 10'h000};
    else if (inf_b)             sum_c_o = {sb, 5'h1F, 10'h000};
    else if (zero_a && zero_b)  sum_c_o = {sa & sb, 15'h0000};
    else if (zero_a)            sum_c_o = b_i;
    else if (zero_b)            sum_c_o = a_i;
    else if (sum == '0)         sum_c_o = FP16_ZERO;
    else if (e >= 7'sd31)       sum_c_o = {sl, 5'h1F, 10'h000};
    else if (e <= 7'sd0)        sum_c_o = {sl, 15'h0000};
    else                        sum_c_o = {sl, e[4:0], mr[9:0]};
  end

endmodule

// File: rtl/fp16_dot_unit.sv
// Sequential FP16 dot-product engine: one pair per LOAD/MUL/ACC round,
// sequential accumulation, sticky done until start is released.
module fp16_dot_unit
  import fp16_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_LENGTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WIDTH-1:0]              a_in,
  input  logic [WIDTH-1:0]              b_in,
  input  logic [$clog2(MAX_LENGTH)-1:0] length,
  output logic [WIDTH-1:0]              result,
  output logic                          done
);

  localparam int unsigned LEN_W = $clog2(MAX_LENGTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   prod_q, prod_d, acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0]   sum_c;
  logic               pu_ready;

  // Feeder strobe: the next pair must be on a_in/b_in while this is high.
  assign pu_ready = (state_q == LOAD);
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign result   = result_q;
  assign done     = done_q;

  fp16_add u_add (
    .a_i     (acc_q),
    .b_i     (prod_q),
    .sum_c_o (sum_c)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    result_d = result_q;
    done_d   = done_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a_in;
          b_d   = b_in;
          len_d = length;
          acc_d = '0;
          cnt_d = '0;
          if (length == '0) begin
            state_d  = DONE;
            result_d = FP16_ZERO;
            done_d   = 1'b1;
          end else begin
            state_d = MUL;
          end
        end
      end
      LOAD: begin
        if (pu_ready) begin
          a_d     = a_in;
          b_d     = b_in;
          state_d = MUL;
        end
      end
      MUL: begin
        prod_d  = fp16_mul(a_q, b_q);
        state_d = ACC;
      end
      ACC: begin
        acc_d = sum_c;
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) begin
          state_d  = DONE;
          result_d = sum_c;
          done_d   = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_fp16_dot_unit.sv
// Scoreboard bench for fp16_dot_unit: directed vectors push expected sums,
// a negedge monitor pops and compares on every rising done.
module tb_fp16_dot_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a_in, b_in;
  logic [5:0]  length;
  logic [15:0] result;
  logic        done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];
  logic        done_prev = 1'b0;

  fp16_dot_unit #(.WIDTH(16), .MAX_LENGTH(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .length (length),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endfunction

  // Monitor: every new done pops one expected result.
  always @(negedge clk) begin : monitor
    logic [15:0] e;
    string       nm;
    if (reset && done && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got result 0x%0h, expected no result", result);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, 32'(result), 32'(e));
      end
    end
    done_prev = done;
  end

  // av/bv pack element k in bits [16k+15:16k].
  task automatic run_vec(input string nm, input int n, input logic [63:0] av,
                         input logic [63:0] bv, input logic [15:0] exp_r);
    int edges;
    int pu_cnt;
    int k;
    exp_q.push_back(exp_r);
    name_q.push_back(nm);
    @(negedge clk);
    start  = 1'b1;
    length = 6'(n);
    a_in   = av[15:0];
    b_in   = bv[15:0];
    @(posedge clk);
    edges  = 0;
    pu_cnt = 0;
    k      = 1;
    while (edges < 300) begin
      @(negedge clk);
      if (done) break;
      if (dut.pu_ready && k < 4) begin
        pu_cnt++;
        a_in = av[16*k +: 16];
        b_in = bv[16*k +: 16];
        k++;
      end else begin
        a_in = 16'h7E00;
        b_in = 16'h7E00;
      end
      @(posedge clk);
      edges++;
    end
    if (!done) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    check({nm, "_latency"}, 32'(edges), (n == 0) ? 32'd0 : 32'(3 * n - 1));
    check({nm, "_pu_ready_cycles"}, 32'(pu_cnt), (n == 0) ? 32'd0 : 32'(n - 1));
    @(posedge clk);
    @(negedge clk);
    check({nm, "_done_held"}, 32'(done), 32'd1);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({nm, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int pu;
    int edges;
    reset  = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    length = '0;
    #12;
    check("reset_result", 32'(result), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_pu_ready", 32'(dut.pu_ready), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    run_vec("basic_len4", 4, {16'h4400, 16'h4200, 16'h3C00, 16'h4000},
            {16'h3C00, 16'h4000, 16'h3C00, 16'h4000}, 16'h4B80);
    run_vec("len1_neg6", 1, 64'h4200, 64'hC000, 16'hC600);
    run_vec("len0_zero", 0, 64'h4200, 64'h4000, 16'h0000);
    run_vec("cancel", 2, 64'hBC00_3C00, 64'h3C00_3C00, 16'h0000);
    run_vec("inf_times_zero", 1, 64'h7C00, 64'h0000, 16'h7E00);
    run_vec("overflow", 1, 64'h7BFF, 64'h4000, 16'h7C00);
    run_vec("inf_minus_inf", 2, 64'hFC00_7C00, 64'h3C00_3C00, 16'h7E00);
    run_vec("subnormal_flush", 1, 64'h0001, 64'h3C00, 16'h0000);
    run_vec("round_tie_even", 2, 64'h1000_3C00, 64'h3C00_3C00, 16'h3C00);
    run_vec("round_up", 1, 64'h3C01, 64'h3C01, 16'h3C02);

    // Abort in MUL of element 2; the held 0x3C02 must be cleared.
    @(negedge clk);
    start  = 1'b1;
    length = 6'd4;
    a_in   = 16'h4000;
    b_in   = 16'h4000;
    @(posedge clk);
    pu    = 0;
    edges = 0;
    while (pu < 2 && edges < 100) begin
      @(negedge clk);
      if (dut.pu_ready) begin
        pu++;
        a_in = 16'h3C00;
        b_in = 16'h3C00;
      end
      @(posedge clk);
      edges++;
    end
    check("abort_reached_elem2", 32'(pu), 32'd2);
    #1;
    reset = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_pu_ready", 32'(dut.pu_ready), 32'h0);
    check("abort_acc", 32'(dut.acc_q), 32'h0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    run_vec("basic_after_abort", 4, {16'h4400, 16'h4200, 16'h3C00, 16'h4000},
            {16'h3C00, 16'h4000, 16'h3C00, 16'h4000}, 16'h4B80);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
